alu: RTL and testbench

- Registered 32-bit arithmetic/logic unit with integer ops and IEEE-754 single-precision add, subtract and multiply.
- Result is presented on a 64-bit output so the full integer product or carry fits.
- Instances are chained in trees, with out[31:0] feeding the next operand, to evaluate series sums such as Taylor expansions of exp(x).

---
 rtl/alu.sv | 102 ++++++++++
 tb/tb_alu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: registered 32-bit integer and FP32 (add/sub/mul, flush-to-zero, RNE) arithmetic/logic unit
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  opcode,
  output logic [63:0] out
);
  localparam logic [31:0] qnan = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // m[26] is the leading one, m[2:0] are guard/round/sticky
  function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e, input logic [26:0] m);
    logic [24:0] r;
    logic signed [9:0] ef;
    logic [30:0] pk;
    r = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
    ef = e + $signed({9'b0, r[24]});
    // the hidden bit re-adds the 1 taken off the exponent; a rounding carry adds one more
    pk = {e[7:0] - 8'd1, 23'b0} + {6'b0, r};
    round_pack = ef >= 10'sd255 ? {s, 8'hFF, 23'b0} : ef <= 10'sd0 ? {s, 31'b0} : {s, pk};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi, xz, yz, swap, sl, ss;
    logic [7:0] el, es, d;
    logic [23:0] xm, ym, ml, ms;
    logic [49:0] sh;
    logic [26:0] ya, nm;
    logic [27:0] sum;
    logic [4:0] lz;
    logic signed [9:0] e;
    xn = &x[30:23] & |x[22:0];
    yn = &y[30:23] & |y[22:0];
    xi = &x[30:23] & ~|x[22:0];
    yi = &y[30:23] & ~|y[22:0];
    xz = ~|x[30:23];
    yz = ~|y[30:23];
    xm = xz ? 24'b0 : {1'b1, x[22:0]};
    ym = yz ? 24'b0 : {1'b1, y[22:0]};
    swap = (yz ? 31'b0 : y[30:0]) > (xz ? 31'b0 : x[30:0]);
    {sl, el, ml} = swap ? {y[31], y[30:23], ym} : {x[31], x[30:23], xm};
    {ss, es, ms} = swap ? {x[31], x[30:23], xm} : {y[31], y[30:23], ym};
    d = el - es;
    sh = {ms, 26'b0} >> d;
    ya = d >= 8'd26 ? {26'b0, |ms} : {sh[49:24], |sh[23:0]};
    sum = (sl ^ ss) ? {1'b0, ml, 3'b0} - {1'b0, ya} : {1'b0, ml, 3'b0} + {1'b0, ya};
    lz = lzc27(sum[26:0]);
    nm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
    e = sum[27] ? $signed({2'b0, el}) + 10'sd1 : $signed({2'b0, el}) - $signed({5'b0, lz});
    fp_add = (xn | yn | (xi & yi & (x[31] ^ y[31]))) ? qnan : xi ? x : yi ? y :
             sum == 28'd0 ? {x[31] & y[31], 31'b0} : round_pack(sl, e, nm);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, xn, yn, xi, yi, xz, yz;
    logic [47:0] p;
    logic [26:0] nm;
    logic signed [9:0] e;
    s = x[31] ^ y[31];
    xn = &x[30:23] & |x[22:0];
    yn = &y[30:23] & |y[22:0];
    xi = &x[30:23] & ~|x[22:0];
    yi = &y[30:23] & ~|y[22:0];
    xz = ~|x[30:23];
    yz = ~|y[30:23];
    p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    nm = p[47] ? {p[47:24], p[23], 1'b0, |p[22:0]} : {p[46:23], p[22], 1'b0, |p[21:0]};
    e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127 + $signed({9'b0, p[47]});
    fp_mul = (xn | yn | (xi & yz) | (yi & xz)) ? qnan : (xi | yi) ? {s, 8'hFF, 23'b0} :
             (xz | yz) ? {s, 31'b0} : round_pack(s, e, nm);
  endfunction

  logic [31:0] diff;
  logic [63:0] nxt;

  always_comb begin
    diff = a - b;
    nxt = '0;
    case (opcode)
      4'h0: nxt = {31'b0, {1'b0, a} + {1'b0, b}};
      4'h1: nxt = {{32{diff[31]}}, diff};
      4'h2: nxt = {32'b0, a & b};
      4'h3: nxt = {32'b0, a | b};
      4'h4: nxt = {32'b0, a ^ b};
      4'h5: nxt = {32'b0, fp_add(a, b)};
      4'h6: nxt = {32'b0, fp_add(a, {~b[31], b[30:0]})};
      4'h7: nxt = {32'b0, fp_mul(a, b)};
      4'h8: nxt = {32'b0, a} * {32'b0, b};
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) out <= '0;
    else out <= nxt;
endmodule

// File: tb/tb_alu.sv
// tb_alu: vector table, exact wide-integer FP reference model with random stimulus, and a Taylor-series tree
module tb_alu;
  localparam logic [31:0] qnan = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] a, b;
  logic [3:0] opcode;
  logic [63:0] out;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode), .out(out));

  logic [31:0] ca [6];
  logic [31:0] cb [6];
  logic [63:0] mo [6];
  logic [63:0] so [3];
  logic [63:0] s3a, s3b, fin;

  for (genvar i = 0; i < 6; i++) begin : g_mul
    alu u (.clk(clk), .rst_n(rst_n), .a(ca[i]), .b(cb[i]), .opcode(4'b0111), .out(mo[i]));
  end
  for (genvar i = 0; i < 3; i++) begin : g_add
    alu u (.clk(clk), .rst_n(rst_n), .a(mo[2*i][31:0]), .b(mo[2*i+1][31:0]), .opcode(4'b0101), .out(so[i]));
  end
  alu u_s3a (.clk(clk), .rst_n(rst_n), .a(so[0][31:0]), .b(so[1][31:0]), .opcode(4'b0101), .out(s3a));
  alu u_s3b (.clk(clk), .rst_n(rst_n), .a(so[2][31:0]), .b(32'h0), .opcode(4'b0101), .out(s3b));
  alu u_s4 (.clk(clk), .rst_n(rst_n), .a(s3a[31:0]), .b(s3b[31:0]), .opcode(4'b0101), .out(fin));

  function automatic logic is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0;
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'd0;
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  // exact magnitude in units of 2^-300
  function automatic logic [599:0] fmag(input logic [31:0] x);
    logic [599:0] m;
    m = 600'({1'b1, x[22:0]});
    return m << (int'(x[30:23]) + 150);
  endfunction

  function automatic logic [31:0] ref_round(input logic s, input logic [599:0] mag);
    int p, sh, ex;
    logic [599:0] q, rem, half;
    p = 0;
    for (int i = 0; i < 600; i++) if (mag[i]) p = i;
    sh = p - 23;
    q = mag >> sh;
    rem = mag - (q << sh);
    half = 600'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 600'd1;
    ex = p - 173;
    if (q[24]) begin
      q = q >> 1;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 23'b0};
    if (ex <= 0) return {s, 31'b0};
    return {s, 8'(ex), q[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [599:0] xm, ym, m;
    logic s;
    if (is_nan(x) || is_nan(y)) return qnan;
    if (is_inf(x) && is_inf(y)) return x[31] == y[31] ? x : qnan;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    xm = is_zero(x) ? 600'd0 : fmag(x);
    ym = is_zero(y) ? 600'd0 : fmag(y);
    if (x[31] == y[31]) begin
      s = x[31];
      m = xm + ym;
    end else if (xm > ym) begin
      s = x[31];
      m = xm - ym;
    end else if (ym > xm) begin
      s = y[31];
      m = ym - xm;
    end else return 32'h0;
    if (m == 600'd0) return {s, 31'b0};
    return ref_round(s, m);
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic [599:0] p;
    s = x[31] ^ y[31];
    if (is_nan(x) || is_nan(y)) return qnan;
    if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x))) return qnan;
    if (is_inf(x) || is_inf(y)) return {s, 8'hFF, 23'b0};
    if (is_zero(x) || is_zero(y)) return {s, 31'b0};
    p = 600'({1'b1, x[22:0]}) * 600'({1'b1, y[22:0]});
    p = p << (int'(x[30:23]) + int'(y[30:23]));
    return ref_round(s, p);
  endfunction

  function automatic logic [63:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    case (op)
      4'h0: return 64'(x) + 64'(y);
      4'h1: return 64'(longint'($signed(x - y)));
      4'h2: return 64'(x & y);
      4'h3: return 64'(x | y);
      4'h4: return 64'(x ^ y);
      4'h5: return {32'b0, ref_add(x, y)};
      4'h6: return {32'b0, ref_add(x, {~y[31], y[30:0]})};
      4'h7: return {32'b0, ref_mul(x, y)};
      4'h8: return 64'(x) * 64'(y);
      default: return 64'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [63:0] want;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop, input logic [63:0] vw);
    vec_t v;
    v.a = va;
    v.b = vb;
    v.op = vop;
    v.want = vw;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop);
    a = va;
    b = vb;
    opcode = vop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, t [6], s2 [3], u0, u1, gold;
    logic [31:0] specials [8];
    logic [3:0] op;
    logic hi;
    specials = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h7F7F_FFFF};
    for (int i = 0; i < 6; i++) begin
      ca[i] = 32'h0;
      cb[i] = 32'h0;
    end
    rst_n = 1'b0;
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    opcode = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", out, 64'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_fadd", out, 64'h0000_0000_4080_0000);

    add_vec(32'h4110_0000, 32'h3F00_0000, 4'h7, 64'h4090_0000);
    add_vec(32'h41D8_0000, 32'h3E2A_AAAB, 4'h7, 64'h4090_0000);
    add_vec(32'h4080_0000, 32'h4090_0000, 4'h5, 64'h4108_0000);
    add_vec(32'h4040_0000, 32'h3F80_0000, 4'h6, 64'h4000_0000);
    add_vec(32'h4120_0000, 32'h4120_0000, 4'h6, 64'h0);
    add_vec(32'h7F80_0000, 32'h0000_0000, 4'h7, 64'h7FC0_0000);
    add_vec(32'h7F7F_FFFF, 32'h4000_0000, 4'h7, 64'h7F80_0000);
    add_vec(32'h0040_0000, 32'h3F80_0000, 4'h5, 64'h3F80_0000);
    add_vec(32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 64'h0000_0001_0000_0000);
    add_vec(32'h0000_0001, 32'h0000_0002, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 64'hFFFF_FFFE_0000_0001);
    add_vec(32'hF0F0_F0F0, 32'hFFFF_0000, 4'h4, 64'h0000_0000_0F0F_F0F0);
    add_vec(32'hF0F0_F0F0, 32'hFFFF_0000, 4'h2, 64'h0000_0000_F0F0_0000);
    add_vec(32'hF0F0_F0F0, 32'hFFFF_0000, 4'h3, 64'h0000_0000_FFFF_F0F0);
    add_vec(32'h1234_5678, 32'h9ABC_DEF0, 4'hF, 64'h0);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9, 64'h0);
    add_vec(32'h7F80_0000, 32'h7F80_0000, 4'h6, 64'h7FC0_0000);
    add_vec(32'h7F80_0000, 32'h3F80_0000, 4'h5, 64'h7F80_0000);
    add_vec(32'h7FC0_0001, 32'h0000_0000, 4'h5, 64'h7FC0_0000);
    add_vec(32'h0080_0000, 32'h0080_0000, 4'h7, 64'h0);
    add_vec(32'hBF80_0000, 32'h3F80_0000, 4'h5, 64'h0);
    add_vec(32'hC000_0000, 32'h3F80_0000, 4'h7, 64'hC000_0000);
    add_vec(32'h3F80_0000, 32'h3380_0000, 4'h5, 64'h3F80_0000);
    add_vec(32'h3F80_0001, 32'h3380_0000, 4'h5, 64'h3F80_0002);
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec[%0d] op%0d", i, vecs[i].op), out, vecs[i].want);
    end

    a = 32'd5;
    b = 32'd6;
    opcode = 4'h0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", out, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_mid_reset", out, 64'd11);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(5, 7));
      case ($urandom_range(0, 4))
        1: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
        2: begin
          ra[30:23] = 8'($urandom_range(100, 154));
          rb[30:23] = 8'($urandom_range(100, 154));
        end
        3: rb[30:23] = ra[30:23] - 8'($urandom_range(20, 30));
        4: rb = specials[$urandom_range(0, 7)];
        default: ;
      endcase
      step(ra, rb, op);
      check($sformatf("rnd[%0d] op%0d a=%h b=%h", i, op, ra, rb), out, ref_alu(ra, rb, op));
    end

    ca = '{32'h3F80_0000, 32'h4040_0000, 32'h4110_0000, 32'h41D8_0000, 32'h42A2_0000, 32'h4373_0000};
    cb = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3E2A_AAAB, 32'h3D2A_AAAB, 32'h3C08_8889};
    for (int i = 0; i < 6; i++) t[i] = ref_mul(ca[i], cb[i]);
    for (int i = 0; i < 3; i++) s2[i] = ref_add(t[2*i], t[2*i+1]);
    u0 = ref_add(s2[0], s2[1]);
    u1 = ref_add(s2[2], 32'h0);
    gold = ref_add(u0, u1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("chain_edge%0d", i), fin, 64'h0);
    end
    @(posedge clk);
    #1;
    check("chain_sum", fin, {32'b0, gold});
    hi = |fin[63:32] | |s3a[63:32] | |s3b[63:32];
    for (int i = 0; i < 6; i++) hi = hi | |mo[i][63:32];
    for (int i = 0; i < 3; i++) hi = hi | |so[i][63:32];
    check("chain_upper_zero", {63'b0, hi}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
